// File: rtl/ni_pkg.sv
// Shared definitions for the NI receive-side VC scheduler: FSM encoding,
// default sizing constants and the index-width helper.
package ni_pkg;

  localparam int NI_V_DEFAULT         = 4;
  localparam int NI_TIMEOUT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } ni_rx_state_t;

  // ceil(log2(n)), never less than 1 so a single-VC build still has a num bit
  function automatic int ni_log2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ni_rx_rr_arbiter.sv
// Round-robin winner select: first requester at or after the pointer,
// returned one-hot.
module ni_rx_rr_arbiter
  import ni_pkg::*;
#(
  parameter  int V  = NI_V_DEFAULT,
  localparam int NW = ni_log2(V)
) (
  input  logic [V-1:0]  req,
  input  logic [NW-1:0] pointer,
  output logic [V-1:0]  grant
);

  logic [2*V-1:0] req_dbl;
  logic [2*V-1:0] gnt_dbl;
  logic [V-1:0]   req_rot;
  logic [V-1:0]   gnt_rot;

  // Rotate so the pointer position is bit 0, take the lowest set bit, rotate back.
  assign req_dbl = {req, req} >> pointer;
  assign req_rot = req_dbl[V-1:0];
  assign gnt_rot = req_rot & (~req_rot + V'(1));
  assign gnt_dbl = {gnt_rot, gnt_rot} << pointer;
  assign grant   = gnt_dbl[2*V-1:V];

endmodule

// File: rtl/ni_vc_rx_scheduler.sv
// Shares one receive DMA FSM between V virtual channels using round-robin grants.
// Optional watchdog abort in WAIT_DONE is enabled by defining NI_RX_WATCHDOG_EN.
module ni_vc_rx_scheduler
  import ni_pkg::*;
#(
  parameter  int V         = NI_V_DEFAULT,
  parameter  int TIMEOUT_W = NI_TIMEOUT_W_DEFAULT,
  localparam int NW        = ni_log2(V)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [V-1:0]         vc_got_packet,
  input  logic [V-1:0]         vc_rx_en,
  input  logic                 receive_fsm_is_ideal,
  input  logic                 receive_done,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 receive_start,
  output logic [V-1:0]         receive_vc_sel,
  output logic [NW-1:0]        receive_vc_num,
  output logic [V-1:0]         vc_rx_en_clr,
  output logic [V-1:0]         vc_saved_set,
  output logic [V-1:0]         vc_rx_abort,
  output logic                 busy
);

  ni_rx_state_t  state_reg;
  logic [NW-1:0] ptr_reg;
  logic [V-1:0]  sel_reg;
  logic [NW-1:0] num_reg;

  logic [V-1:0]  req;
  logic [V-1:0]  arb_grant;
  logic [NW-1:0] win_num;
  logic [NW-1:0] ptr_next;
  logic          got_granted;
  logic          start_fire;
  logic          done_fire;
  logic          abort_fire;

  for (genvar gi = 0; gi < V; gi++) begin : g_req
    assign req[gi] = vc_got_packet[gi] & vc_rx_en[gi];
  end

  ni_rx_rr_arbiter #(.V(V)) u_arb (
    .req     (req),
    .pointer (ptr_reg),
    .grant   (arb_grant)
  );

  always_comb begin
    win_num = '0;
    for (int i = 0; i < V; i++) begin
      if (arb_grant[i]) win_num = win_num | NW'(i);
    end
  end

  assign ptr_next    = (num_reg == NW'(V - 1)) ? '0 : num_reg + NW'(1);
  assign got_granted = |(vc_got_packet & sel_reg);
  assign start_fire  = (state_reg == ST_START) && got_granted;
  assign done_fire   = (state_reg == ST_WAIT_DONE) && receive_done;

`ifdef NI_RX_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_cnt_reg;

  // Counts cycles spent in WAIT_DONE, starting from 0 on the first one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_reg <= '0;
    end else if (state_reg != ST_WAIT_DONE) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + TIMEOUT_W'(1);
    end
  end

  // A done in the limit cycle takes precedence over the abort.
  assign abort_fire = (state_reg == ST_WAIT_DONE) && !receive_done &&
                      (timeout_limit != '0) && (wd_cnt_reg == timeout_limit);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_limit;
  assign abort_fire     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      sel_reg   <= '0;
      num_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if ((req != '0) && receive_fsm_is_ideal) begin
            sel_reg   <= arb_grant;
            num_reg   <= win_num;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (got_granted) begin
            state_reg <= ST_WAIT_DONE;
          end else begin
            sel_reg   <= '0;
            num_reg   <= '0;
            state_reg <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (done_fire || abort_fire) begin
            ptr_reg   <= ptr_next;
            sel_reg   <= '0;
            num_reg   <= '0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          sel_reg   <= '0;
          num_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign receive_start  = start_fire;
  assign receive_vc_sel = sel_reg;
  assign receive_vc_num = num_reg;
  assign vc_rx_en_clr   = start_fire ? sel_reg : '0;
  assign vc_saved_set   = done_fire  ? sel_reg : '0;
  assign vc_rx_abort    = abort_fire ? sel_reg : '0;
  assign busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ni_vc_rx_scheduler.sv
// Bench for ni_vc_rx_scheduler: a cycle-level grant/ownership model checked
// every negedge, plus directed scenarios with literal expectations.
module tb_ni_vc_rx_scheduler;

  localparam int V  = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [V-1:0]  vc_got_packet = '0;
  logic [V-1:0]  vc_rx_en = '0;
  logic          receive_fsm_is_ideal = 1'b0;
  logic          receive_done = 1'b0;
  logic [TW-1:0] timeout_limit = '0;
  logic          receive_start;
  logic [V-1:0]  receive_vc_sel;
  logic [1:0]    receive_vc_num;
  logic [V-1:0]  vc_rx_en_clr;
  logic [V-1:0]  vc_saved_set;
  logic [V-1:0]  vc_rx_abort;
  logic          busy;

  int errors = 0;
  int checks = 0;

  ni_vc_rx_scheduler #(.V(V), .TIMEOUT_W(TW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .vc_got_packet        (vc_got_packet),
    .vc_rx_en             (vc_rx_en),
    .receive_fsm_is_ideal (receive_fsm_is_ideal),
    .receive_done         (receive_done),
    .timeout_limit        (timeout_limit),
    .receive_start        (receive_start),
    .receive_vc_sel       (receive_vc_sel),
    .receive_vc_num       (receive_vc_num),
    .vc_rx_en_clr         (vc_rx_en_clr),
    .vc_saved_set         (vc_saved_set),
    .vc_rx_abort          (vc_rx_abort),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which VC owns the receive FSM (-1 none), whether it has been started,
  // the next VC to favour, and cycles spent waiting for done.
  int m_grant   = -1;
  bit m_started = 1'b0;
  int m_ptr     = 0;
  int m_wd      = 0;

  always @(negedge clk) begin : model
    logic [V-1:0] req_v, e_sel, e_clr, e_saved, e_abort;
    logic         e_start;
    int           e_num, c;
    req_v   = vc_got_packet & vc_rx_en;
    e_sel   = '0; e_clr = '0; e_saved = '0; e_abort = '0;
    e_start = 1'b0; e_num = 0;
    if (reset) begin
      m_grant = -1; m_started = 1'b0; m_ptr = 0; m_wd = 0;
    end
    if (m_grant >= 0) begin
      e_sel[m_grant] = 1'b1;
      e_num = m_grant;
      if (!m_started && vc_got_packet[m_grant]) begin
        e_start = 1'b1;
        e_clr[m_grant] = 1'b1;
      end
      if (m_started && receive_done) e_saved[m_grant] = 1'b1;
`ifdef NI_RX_WATCHDOG_EN
      if (m_started && !receive_done && timeout_limit != 0 && m_wd == int'(timeout_limit))
        e_abort[m_grant] = 1'b1;
`endif
    end
    check("sel", receive_vc_sel, e_sel);
    check("num", receive_vc_num, e_num);
    check("start", receive_start, e_start);
    check("en_clr", vc_rx_en_clr, e_clr);
    check("saved_set", vc_saved_set, e_saved);
    check("abort", vc_rx_abort, e_abort);
    check("busy", busy, (m_grant >= 0));

    if (!reset) begin
      if (m_grant < 0) begin
        if (req_v != 0 && receive_fsm_is_ideal) begin
          for (int k = 0; k < V; k++) begin
            c = (m_ptr + k) % V;
            if (req_v[c] && m_grant < 0) m_grant = c;
          end
          m_started = 1'b0;
        end
      end else if (!m_started) begin
        if (vc_got_packet[m_grant]) begin
          m_started = 1'b1;
          m_wd = 0;
        end else begin
          $display("txn vc=%0d dropped before start", m_grant);
          m_grant = -1;
        end
      end else if (receive_done) begin
        $display("txn vc=%0d saved", m_grant);
        m_ptr = (m_grant + 1) % V;
        m_grant = -1;
        m_started = 1'b0;
      end
`ifdef NI_RX_WATCHDOG_EN
      else if (timeout_limit != 0 && m_wd == int'(timeout_limit)) begin
        $display("txn vc=%0d aborted by watchdog", m_grant);
        m_ptr = (m_grant + 1) % V;
        m_grant = -1;
        m_started = 1'b0;
      end else begin
        m_wd = m_wd + 1;
      end
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    vc_got_packet = '0; vc_rx_en = '0; receive_done = 1'b0;
    @(negedge clk);
    check("rst_outputs", {receive_start, receive_vc_sel, receive_vc_num, vc_rx_en_clr,
                          vc_saved_set, vc_rx_abort, busy}, 0);
    step();
    reset = 1'b0;
  endtask

  // Leaves the caller at the negedge of the cycle where receive_start is high.
  task automatic wait_start(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (receive_start) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got no receive_start expected one within 30 cycles", name);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish by 400000");
    $fatal(1, "bench timeout");
  end

  initial begin
    do_reset();

    // VC1 wins from pointer 0, completes, pointer moves to 2.
    vc_got_packet = 4'b0110; vc_rx_en = 4'b0110; receive_fsm_is_ideal = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    step(); @(negedge clk);
    check("g1_sel", receive_vc_sel, 4'b0010);
    check("g1_num", receive_vc_num, 1);
    check("g1_start", receive_start, 1);
    check("g1_clr", vc_rx_en_clr, 4'b0010);
    step(); receive_done = 1'b1; @(negedge clk);
    check("g1_saved", vc_saved_set, 4'b0010);
    step(); receive_done = 1'b0; @(negedge clk);
    check("g1_idle_sel", receive_vc_sel, 0);
    // VC2 granted, then its packet vanishes during START.
    step(); vc_got_packet = '0; @(negedge clk);
    check("drop_sel", receive_vc_sel, 4'b0100);
    check("drop_start", receive_start, 0);
    check("drop_clr", vc_rx_en_clr, 0);
    step(); vc_got_packet = 4'b1111; vc_rx_en = 4'b1111; @(negedge clk);
    check("drop_idle", busy, 0);
    step(); @(negedge clk);
    check("ptr_kept_sel", receive_vc_sel, 4'b0100);
    check("ptr_kept_start", receive_start, 1);
    step(); receive_done = 1'b1;
    step(); receive_done = 1'b0; vc_got_packet = '0; vc_rx_en = '0;

    // Round-robin order from reset with all VCs requesting.
    do_reset();
    vc_got_packet = 4'b1111; vc_rx_en = 4'b1111; receive_fsm_is_ideal = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_start("rr_wait");
      check("rr_order", receive_vc_num, n % V);
      repeat (3) step();
      receive_done = 1'b1;
      step();
      receive_done = 1'b0;
    end
    vc_got_packet = '0; vc_rx_en = '0;

    // Receive FSM busy holds off the grant.
    do_reset();
    receive_fsm_is_ideal = 1'b0; vc_got_packet = 4'b0001; vc_rx_en = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      step(); @(negedge clk);
      check("hold_busy", busy, 0);
    end
    step(); receive_fsm_is_ideal = 1'b1; @(negedge clk);
    check("hold_sel", receive_vc_sel, 0);
    step(); @(negedge clk);
    check("rise_sel", receive_vc_sel, 4'b0001);
    check("rise_start", receive_start, 1);
    step(); receive_done = 1'b1;
    step(); receive_done = 1'b0; vc_got_packet = '0; vc_rx_en = '0;

    // Asynchronous reset in WAIT_DONE.
    do_reset();
    vc_got_packet = 4'b0100; vc_rx_en = 4'b0100; receive_fsm_is_ideal = 1'b1;
    step(); step();
    vc_got_packet = '0; vc_rx_en = '0;
    #2 reset = 1'b1;
    #1;
    check("arst_sel", receive_vc_sel, 0);
    check("arst_num", receive_vc_num, 0);
    check("arst_busy", busy, 0);
    check("arst_pulses", {receive_start, vc_rx_en_clr, vc_saved_set, vc_rx_abort}, 0);
    step(); reset = 1'b0; receive_done = 1'b1; @(negedge clk);
    check("arst_no_saved", vc_saved_set, 0);
    step(); receive_done = 1'b0; vc_got_packet = 4'b1111; vc_rx_en = 4'b1111;
    step(); @(negedge clk);
    check("arst_ptr0", receive_vc_num, 0);
    step(); receive_done = 1'b1;
    step(); receive_done = 1'b0; vc_got_packet = '0; vc_rx_en = '0;

`ifdef NI_RX_WATCHDOG_EN
    // Watchdog abort 10 cycles into WAIT_DONE, then done wins on the limit cycle.
    do_reset();
    timeout_limit = 10;
    vc_got_packet = 4'b0001; vc_rx_en = 4'b0001; receive_fsm_is_ideal = 1'b1;
    wait_start("wd_wait1");
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      check("wd_abort", vc_rx_abort, (n == 11) ? 4'b0001 : 4'b0000);
    end
    wait_start("wd_wait2");
    repeat (11) step();
    receive_done = 1'b1;
    @(negedge clk);
    check("wd_done_wins_saved", vc_saved_set, 4'b0001);
    check("wd_done_wins_abort", vc_rx_abort, 0);
    step(); receive_done = 1'b0; vc_got_packet = '0; vc_rx_en = '0;
`endif

    // Randomized traffic, three segments with different watchdog limits.
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      timeout_limit = (seg == 0) ? 16'd0 : ((seg == 1) ? 16'd4 : 16'd9);
      for (int n = 0; n < 300; n++) begin
        vc_got_packet        = V'($urandom);
        vc_rx_en             = V'($urandom) | V'($urandom);
        receive_fsm_is_ideal = ($urandom_range(0, 3) != 0);
        receive_done         = ($urandom_range(0, 4) == 0);
        @(negedge clk);
        checks++;
        if ($countones(receive_vc_sel) > 1 || $countones(vc_saved_set) > 1 ||
            $countones(vc_rx_en_clr) > 1 || $countones(vc_rx_abort) > 1) begin
          errors++;
          $display("FAIL onehot: got sel=%b saved=%b clr=%b abort=%b expected at most one bit each",
                   receive_vc_sel, vc_saved_set, vc_rx_en_clr, vc_rx_abort);
        end
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ni_vc_rx_scheduler.md
NI_VC_RX_SCHEDULER -- requirements
Module: ni_vc_rx_scheduler

Interface
REQ-001 SHALL have parameter V, default 4, meaning the number of receive virtual channels sharing one receive DMA FSM.
REQ-002 SHALL have parameter TIMEOUT_W, default 16, meaning the watchdog counter width (used only under REQ-030).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port vc_got_packet, input, V, per-VC "packet waiting in NI buffer".
REQ-006 SHALL have port vc_rx_en, input, V, per-VC receive enable armed by the register bank.
REQ-007 SHALL have port receive_fsm_is_ideal, input, 1, shared receive FSM idle.
REQ-008 SHALL have port receive_done, input, 1, shared receive FSM finished the current packet (one-cycle pulse).
REQ-009 SHALL have port timeout_limit, input, TIMEOUT_W, watchdog limit in cycles; 0 disables the watchdog.
REQ-010 SHALL have port receive_start, output, 1, start pulse to the shared receive FSM.
REQ-011 SHALL have port receive_vc_sel, output, V, one-hot selected VC, held from START through WAIT_DONE.
REQ-012 SHALL have port receive_vc_num, output, log2(V) (min 1), binary index of receive_vc_sel.
REQ-013 SHALL have port vc_rx_en_clr, output, V, one-cycle pulse that disarms the granted VC enable.
REQ-014 SHALL have port vc_saved_set, output, V, one-cycle pulse that sets the granted VC's packet-saved flag.
REQ-015 SHALL have port vc_rx_abort, output, V, one-cycle watchdog abort pulse (constant 0 without REQ-030).
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL form the per-VC request as req[i] = vc_got_packet[i] & vc_rx_en[i].
REQ-018 SHALL implement the states IDLE, START and WAIT_DONE.
REQ-019 In IDLE, when req is non-zero and receive_fsm_is_ideal is high, SHALL register the round-robin winner into receive_vc_sel/receive_vc_num and move to START on the next edge.
REQ-020 SHALL use a round-robin priority pointer: search starts at pointer; pointer resets to 0; after a completion or abort the pointer becomes (granted index + 1) mod V.
REQ-021 In START, if vc_got_packet of the granted VC is still high, SHALL assert receive_start and vc_rx_en_clr[grant] for exactly that cycle, then move to WAIT_DONE.
REQ-022 In START, if the granted VC's request has dropped, SHALL assert nothing, leave the pointer unchanged and return to IDLE.
REQ-023 In WAIT_DONE, on receive_done SHALL pulse vc_saved_set[grant] in the same cycle, advance the pointer and return to IDLE.
REQ-024 SHALL ignore receive_done outside WAIT_DONE.
REQ-025 Latency: a request that wins in IDLE SHALL produce receive_start exactly one cycle later; the next grant is possible no earlier than the cycle after the return to IDLE.
REQ-026 SHALL keep receive_vc_sel at 0 in IDLE; at most one bit of any V-wide output SHALL be set per cycle.
REQ-027 When only one VC requests, SHALL grant it regardless of the pointer; when V = 1, the pointer SHALL stay 0.

Reset
REQ-028 On reset, asynchronously and at any state (including mid-transfer), SHALL force IDLE, pointer 0, and all outputs 0, and SHALL issue no pulses.
REQ-029 Every output SHALL have reset value 0.

Configuration
REQ-030 With macro NI_RX_WATCHDOG_EN defined, SHALL count cycles in WAIT_DONE; when the count equals a non-zero timeout_limit without receive_done, SHALL pulse vc_rx_abort[grant], advance the pointer and return to IDLE; if receive_done arrives in that same cycle, done SHALL win.
REQ-031 Without NI_RX_WATCHDOG_EN, SHALL include no counter, tie vc_rx_abort to 0, ignore timeout_limit, and wait in WAIT_DONE indefinitely.

Structure
REQ-032 SHALL place the state encoding, the log2 function and the default V / TIMEOUT_W constants in shared package ni_pkg.
REQ-033 SHALL implement the pointer-based one-hot winner selection as sub-module ni_rx_rr_arbiter (inputs req and pointer, output one-hot grant), instantiated once.

Verification
REQ-034 V=4, reset, req=4'b0110, fsm idle -> grant VC1 (sel=0010, num=1); receive_start and vc_rx_en_clr=0010 one cycle later; done -> vc_saved_set=0010 and pointer=2.
REQ-035 req=4'b1111 held, done returned 3 cycles after each start -> grants in the order 0,1,2,3,0.
REQ-036 Granted VC's got_packet drops during START -> no receive_start, return to IDLE, pointer unchanged.
REQ-037 Reset asserted in WAIT_DONE -> all outputs 0 immediately; pointer 0; a later done pulse gives no vc_saved_set.
REQ-038 NI_RX_WATCHDOG_EN, timeout_limit=10, no done -> vc_rx_abort[grant] 10 cycles after entering WAIT_DONE; done coincident with the limit -> vc_saved_set only.
REQ-039 receive_fsm_is_ideal=0 with req=4'b0001 -> no grant until it rises; grant follows on the next edge.
